// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, bram-style memory (registered read data) among
// NUM_CH requesters. Each cycle at most one valid request is granted and
// driven combinationally onto the memory port. A MEM_LATENCY-deep tracking
// pipe remembers which channel issued each access and whether it was a write.
// When an access leaves the pipe, a one-cycle response strobe is returned to
// that channel: read data for reads, zero data for write acks.
//
// Build option (macro):
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration. A pointer register
//                                    sets where the search starts, and the
//                                    search wraps around.
//                       undefined -> fixed priority. The lowest index wins, and
//                                    no pointer register is built.
//
// Ports:
//   sysclk         clock, all state on the rising edge
//   rst            asynchronous, active-low reset
//   req_valid      per-channel request valid
//   req_ready      per-channel accept (one-hot or zero), equals the grant
//   req_we         per-channel write (1) / read (0)
//   req_addr       flat addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata      flat write data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_be         flat byte enables, channel i at [i*BE_WIDTH +: BE_WIDTH]
//   rsp_valid      one-hot response strobe
//   rsp_rdata      read data for the strobed channel, 0 otherwise
//   mem_addr       memory word address
//   mem_wdata      memory write data
//   mem_byte_w_en  memory byte write enables
//   mem_r_en       memory read enable
//   mem_rdata      memory read data, valid MEM_LATENCY cycles after the request
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           sysclk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH-1:0]              req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_CH*BE_WIDTH-1:0]     req_be,
    output logic [NUM_CH-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [BE_WIDTH-1:0]            mem_byte_w_en,
    output logic                           mem_r_en,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int LAST = MEM_LATENCY - 1;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic              grant_any;
    logic [CH_W-1:0]   grant_id;
    logic [NUM_CH-1:0] grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;
    logic [CH_W:0]   search_idx;   // one extra bit so ptr+k cannot overflow before the wrap
    logic [CH_W-1:0] search_ch;

    always_comb begin
        grant_any  = 1'b0;
        grant_id   = '0;
        search_idx = '0;
        search_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            search_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (search_idx >= (CH_W+1)'(NUM_CH)) begin
                search_idx = search_idx - (CH_W+1)'(NUM_CH);
            end
            search_ch = search_idx[CH_W-1:0];
            if (!grant_any && req_valid[search_ch]) begin
                grant_any = 1'b1;
                grant_id  = search_ch;
            end
        end
    end

    // The pointer moves to the channel after the winner. It holds when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == CH_W'(NUM_CH - 1)) ? '0 : grant_id + CH_W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority. Scanning downward lets the lowest valid index overwrite.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_any = 1'b1;
                grant_id  = CH_W'(k);
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;

    // -------------------------------------------------------------------------
    // Memory port: muxed straight from the granted channel, zero when idle
    // -------------------------------------------------------------------------
    logic grant_we;

    assign grant_we = grant_any & req_we[grant_id];

    always_comb begin
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_byte_w_en = '0;
        mem_r_en      = 1'b0;
        if (grant_any) begin
            mem_addr  = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            mem_r_en  = ~grant_we;
            if (grant_we) begin
                mem_byte_w_en = req_be[grant_id*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // In-flight tracking. Stage 0 captures every cycle: a bubble when idle,
    // the granted access otherwise. Because req_ready equals the grant, any
    // grant is a transfer.
    // -------------------------------------------------------------------------
    logic [MEM_LATENCY-1:0] vld_q;
    logic [MEM_LATENCY-1:0] we_q;
    logic [CH_W-1:0]        ch_q [MEM_LATENCY];

    logic                   vld_d;
    logic                   we_d;
    logic [CH_W-1:0]        ch_d;

    assign vld_d = grant_any;
    assign we_d  = grant_we;
    assign ch_d  = grant_id;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            we_q  <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                ch_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= vld_d;
            we_q[0]  <= we_d;
            ch_q[0]  <= ch_d;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                vld_q[s] <= vld_q[s-1];
                we_q[s]  <= we_q[s-1];
                ch_q[s]  <= ch_q[s-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response: the last stage lines up with mem_rdata for its access
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rsp
        assign rsp_valid[gi] = vld_q[LAST] && (ch_q[LAST] == CH_W'(gi));
    end

    assign rsp_rdata = (vld_q[LAST] && !we_q[LAST]) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NUM_CH = 3;
    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int ML     = 3;
    localparam int BW     = DW / 8;
    localparam int NCYC   = 420;
    localparam int RST_AT = 200;

    logic                 sysclk = 1'b0;
    logic                 rst    = 1'b0;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    req_we;
    logic [NUM_CH*AW-1:0] req_addr;
    logic [NUM_CH*DW-1:0] req_wdata;
    logic [NUM_CH*BW-1:0] req_be;
    logic [NUM_CH-1:0]    rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [BW-1:0]        mem_byte_w_en;
    logic                 mem_r_en;
    logic [DW-1:0]        mem_rdata;

    always #5 sysclk = ~sysclk;

    mem_port_arbiter #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML)
    ) dut (
        .sysclk(sysclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_w_en(mem_byte_w_en),
        .mem_r_en(mem_r_en), .mem_rdata(mem_rdata)
    );

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    // Environment memory: 16 words (address bits [3:0]), read latency ML.
    // Cycles with no read feed random junk into the read pipe.
    logic          mem_init = 1'b1;
    logic [DW-1:0] mem     [16];
    logic [DW-1:0] rd_pipe [ML];
    assign mem_rdata = rd_pipe[ML-1];

    always @(posedge sysclk) begin
        if (mem_init) begin
            for (int a = 0; a < 16; a++) mem[a] <= init_val(a);
        end else begin
            for (int b = 0; b < BW; b++)
                if (mem_byte_w_en[b]) mem[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        rd_pipe[0] <= mem_r_en ? mem[mem_addr[3:0]] : DW'($urandom);
        for (int s = 1; s < ML; s++) rd_pipe[s] <= rd_pipe[s-1];
    end

    // Scoreboard
    typedef struct {
        int            ch;
        int            due;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle the response port must equal the scoreboard head
    // if that response is due now, and must be silent otherwise.
    initial begin
        logic [NUM_CH-1:0] exp_v;
        logic [DW-1:0]     exp_d;
        forever begin
            @(negedge sysclk);
            exp_v = '0;
            exp_d = '0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_v = NUM_CH'(1) << sb[0].ch;
                exp_d = sb[0].data;
                $display("rsp  cyc=%0d ch=%0d data=%08h", cyc, sb[0].ch, exp_d);
                void'(sb.pop_front());
            end
            check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            check("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
        end
    end

    // Requester state and reference model
    logic [DW-1:0] ref_mem [16];
    logic          pend  [NUM_CH];
    logic          p_we  [NUM_CH];
    logic [AW-1:0] p_addr[NUM_CH];
    logic [DW-1:0] p_wd  [NUM_CH];
    logic [BW-1:0] p_be  [NUM_CH];
    int            ptr = 0;

    task automatic drive();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            req_valid[ch]            = pend[ch];
            req_we[ch]               = p_we[ch];
            req_addr [ch*AW +: AW]   = p_addr[ch];
            req_wdata[ch*DW +: DW]   = p_wd[ch];
            req_be   [ch*BW +: BW]   = p_be[ch];
        end
    endtask

    initial begin
        int prob;
        int eg;
        int idx;
        int c;
        logic [DW-1:0] rd;

        for (int a = 0; a < 16; a++) ref_mem[a] = init_val(a);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pend[ch] = 1'b0; p_we[ch] = 1'b0; p_addr[ch] = '0; p_wd[ch] = '0; p_be[ch] = '0;
        end
        drive();

        // Reset state, plus a request presented during reset: the grant and
        // the memory port are still combinational.
        repeat (3) @(negedge sysclk);
        #1;
        check("reset_ready_idle", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        pend[1] = 1'b1; p_addr[1] = 12'h010; drive();
        #1;
        check("reset_ready_comb", 64'(req_ready), 64'b010);
        check("reset_mem_r_en", 64'(mem_r_en), 64'd1);
        check("reset_mem_addr", 64'(mem_addr), 64'h010);
        pend[1] = 1'b0; drive();
        mem_init = 1'b0;
        @(negedge sysclk);
        #1 rst = 1'b1;

        for (int it = 0; it < NCYC; it++) begin
            @(negedge sysclk);
            #1;
            c = cyc;
            if      (it < 150) prob = 50;
            else if (it < 250) prob = 100;
            else if (it < 300) prob = 0;
            else               prob = 30;

            if (it == RST_AT) begin
                // Reset with accesses in flight: none of them may respond.
                rst = 1'b0;
                sb.delete();
                for (int ch = 0; ch < NUM_CH; ch++) pend[ch] = 1'b0;
                ptr = 0;
                $display("rst  cyc=%0d pulse, in-flight accesses dropped", c);
            end else begin
                rst = 1'b1;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (!pend[ch] && $urandom_range(99) < prob) begin
                        pend[ch]   = 1'b1;
                        p_we[ch]   = 1'($urandom_range(1));
                        p_addr[ch] = AW'($urandom_range(4095));
                        p_wd[ch]   = DW'($urandom);
                        p_be[ch]   = BW'($urandom_range(15));
                    end
                end
            end
            drive();
            #1;

            // Expected winner: first pending channel in priority order
            eg = -1;
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
                idx = (ptr + k) % NUM_CH;
`else
                idx = k;
`endif
                if (eg < 0 && pend[idx]) eg = idx;
            end

            if (eg < 0) begin
                check("req_ready", 64'(req_ready), 64'd0);
                check("mem_idle", {mem_addr, mem_wdata, mem_byte_w_en, mem_r_en},
                      64'd0);
            end else begin
                check("req_ready", 64'(req_ready), 64'(NUM_CH'(1) << eg));
                check("mem_addr", 64'(mem_addr), 64'(p_addr[eg]));
                check("mem_wdata", 64'(mem_wdata), 64'(p_wd[eg]));
                check("mem_byte_w_en", 64'(mem_byte_w_en), 64'(p_we[eg] ? p_be[eg] : '0));
                check("mem_r_en", 64'(mem_r_en), 64'(!p_we[eg]));
                if (p_we[eg]) begin
                    for (int b = 0; b < BW; b++)
                        if (p_be[eg][b]) ref_mem[p_addr[eg][3:0]][b*8 +: 8] = p_wd[eg][b*8 +: 8];
                    rd = '0;
                end else begin
                    rd = ref_mem[p_addr[eg][3:0]];
                end
                sb.push_back('{ch: eg, due: c + ML, data: rd});
                $display("req  cyc=%0d ch=%0d %s addr=%03h wd=%08h be=%h", c, eg,
                         p_we[eg] ? "WR" : "RD", p_addr[eg], p_wd[eg], p_be[eg]);
                pend[eg] = 1'b0;
                ptr = (eg + 1) % NUM_CH;
            end
        end

        // Drain and confirm that every expected response arrived.
        for (int ch = 0; ch < NUM_CH; ch++) pend[ch] = 1'b0;
        drive();
        repeat (ML + 3) @(negedge sysclk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
